// File: rtl/mmac_pkg.sv
// Shared constants and types for the sequential matrix multiply/accumulate unit.
package mmac_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Width of the element index that walks all N*N result positions.
  function automatic int idx_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  localparam int DEF_IW = idx_width(DEF_N);

endpackage

// File: rtl/mmac_dot_lane.sv
// Combinational N-term unsigned dot product: N multipliers feeding one sum.
module mmac_dot_lane
  import mmac_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int PW = 2 * DW + $clog2(N)
) (
  input  logic [N*DW-1:0] row,
  input  logic [N*DW-1:0] col,
  output logic [PW-1:0]   dot
);

  logic [2*DW-1:0] prod [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      prod[k] = (2*DW)'(row[k*DW +: DW]) * (2*DW)'(col[k*DW +: DW]);
    end
  end

  always_comb begin
    dot = '0;
    for (int k = 0; k < N; k++) begin
      dot = dot + PW'(prod[k]);
    end
  end

endmodule

// File: rtl/mmac_seq_unit.sv
// Sequential N x N matrix multiply/accumulate, one result element per cycle.
// Build option: define MMAC_SATURATE_EN to clamp overflowing elements instead of wrapping.
module mmac_seq_unit
  import mmac_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*DW-1:0] mat_a,
  input  logic [N*N*DW-1:0] mat_b,
  input  logic              acc_en,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] result,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  localparam int NN = N * N;
  localparam int IW = idx_width(N);
  localparam int PW = 2 * DW + $clog2(N);
  localparam int SW = ((PW > AW) ? PW : AW) + 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and in_ready/out_valid come from
  // registered state only, so no input reaches an output combinationally.

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [NN*DW-1:0]  a_q, b_q;
  logic              acc_q;
  logic [AW-1:0]     bank_q [NN];
  logic              ovf_q;
  logic              rdy_q;

  logic              accept;
  int                sel_r, sel_c;
  logic [N*DW-1:0]   row_v, col_v;
  logic [PW-1:0]     dot;
  logic [SW-1:0]     sum;
  logic              wr_ovf;
  logic [AW-1:0]     wr_val;

  assign accept = (state_q == IDLE) && rdy_q && in_valid && !clear;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = COMPUTE;
      COMPUTE: if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row r of A and column c of B for the element currently addressed by idx.
  always_comb begin
    sel_r = int'(idx_q) / N;
    sel_c = int'(idx_q) % N;
    row_v = '0;
    col_v = '0;
    for (int k = 0; k < N; k++) begin
      row_v[k*DW +: DW] = a_q[(sel_r*N + k)*DW +: DW];
      col_v[k*DW +: DW] = b_q[(k*N + sel_c)*DW +: DW];
    end
  end

  mmac_dot_lane #(.N(N), .DW(DW), .PW(PW)) u_lane (
    .row (row_v),
    .col (col_v),
    .dot (dot)
  );

  // Sum is wide enough that any bit above AW signals an overflowing element.
  always_comb begin
    sum    = (acc_q ? SW'(bank_q[idx_q]) : '0) + SW'(dot);
    wr_ovf = |sum[SW-1:AW];
`ifdef MMAC_SATURATE_EN
    wr_val = wr_ovf ? '1 : sum[AW-1:0];
`else
    wr_val = sum[AW-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= 1'b0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
      for (int i = 0; i < NN; i++) bank_q[i] <= '0;
    end else begin
      rdy_q <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (clear) begin
            ovf_q <= 1'b0;
            for (int i = 0; i < NN; i++) bank_q[i] <= '0;
          end else if (accept) begin
            a_q   <= mat_a;
            b_q   <= mat_b;
            acc_q <= acc_en;
            idx_q <= '0;
          end
        end
        COMPUTE: begin
          bank_q[idx_q] <= wr_val;
          ovf_q         <= ovf_q | wr_ovf;
          idx_q         <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NN; g++) begin : g_res
    assign result[g*AW +: AW] = bank_q[g];
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q == DONE);
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmac_seq_unit.sv
// Directed bench for mmac_seq_unit: a default 4x4/8/32 instance and an AW=16 overflow instance.
module tb_mmac_seq_unit;
  import mmac_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid, acc_en, clear, out_ready;
  logic [127:0] mat_a, mat_b;
  logic         in_ready, out_valid, ovf;
  logic [511:0] result;
  logic [1:0]   dbg_state;

  logic         h_in_valid, h_out_ready;
  logic [127:0] h_mat;
  logic         h_in_ready, h_out_valid, h_ovf;
  logic [255:0] h_result;
  logic [1:0]   h_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mmac_seq_unit #(.N(4), .DW(8), .AW(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b), .acc_en(acc_en), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  mmac_seq_unit #(.N(4), .DW(8), .AW(16)) dut16 (
    .clock(clock), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .mat_a(h_mat), .mat_b(h_mat), .acc_en(1'b0), .clear(1'b0),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result), .ovf(h_ovf),
    .dbg_state(h_dbg_state)
  );

  function automatic logic [127:0] mat_fill(input logic [7:0] v);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = v;
    return m;
  endfunction

  function automatic logic [127:0] mat_ident();
    logic [127:0] m = '0;
    for (int i = 0; i < 4; i++) m[(i*4 + i)*8 +: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [127:0] mat_seq();
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'(i + 1);
    return m;
  endfunction

  function automatic logic [511:0] res_fill(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] res_seq();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(i + 1);
    return r;
  endfunction

  function automatic logic [255:0] res16_fill(input logic [15:0] v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operand set, then wait (bounded) for out_valid.
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic acc,
                        output int cyc, output logic rdy_low);
    @(negedge clock);
    mat_a = a; mat_b = b; acc_en = acc; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 1;
    rdy_low = 1'b1;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic handoff();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic rdy_low;
    logic [511:0] part;

    reset = 1'b0; in_valid = 1'b0; acc_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    mat_a = '0; mat_b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_mat = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_state", dbg_state, 2'(IDLE));
    chk("rst16_result", h_result, '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Identity times sequence reproduces B with the documented latency.
    run_op(mat_ident(), mat_seq(), 1'b0, cyc, rdy_low);
    chk("ident_latency", 32'(cyc), 32'd17);
    chk("ident_ready_low", rdy_low, 1'b1);
    chk("ident_out_valid", out_valid, 1'b1);
    chk("ident_result", result, res_seq());
    handoff();
    chk("ident_ready_after", in_ready, 1'b1);
    chk("ident_valid_after", out_valid, 1'b0);

    run_op(mat_fill(8'd1), mat_fill(8'd1), 1'b0, cyc, rdy_low);
    chk("ones_result", result, res_fill(32'd4));
    handoff();
    run_op(mat_fill(8'd1), mat_fill(8'd1), 1'b1, cyc, rdy_low);
    chk("ones_acc_result", result, res_fill(32'd8));
    chk("ones_acc_ovf", ovf, 1'b0);
    handoff();

    // Clear wins over a simultaneous in_valid.
    @(negedge clock);
    clear = 1'b1; in_valid = 1'b1; acc_en = 1'b0;
    mat_a = mat_fill(8'd7); mat_b = mat_fill(8'd7);
    @(posedge clock); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_result", result, '0);
    chk("clear_ready", in_ready, 1'b1);
    chk("clear_state", dbg_state, 2'(IDLE));

    run_op(mat_fill(8'd2), mat_fill(8'd3), 1'b1, cyc, rdy_low);
    chk("two_three_result", result, res_fill(32'd24));

    // Back-pressure in DONE with a competing operand set offered.
    @(negedge clock);
    in_valid = 1'b1; mat_a = mat_fill(8'd9); mat_b = mat_fill(8'd9); acc_en = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
      chk("hold_result", result, res_fill(32'd24));
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_ovf", ovf, 1'b0);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    handoff();
    chk("hold_ready_after", in_ready, 1'b1);
    @(posedge clock); #1;
    chk("hold_no_accept", dbg_state, 2'(IDLE));
    chk("hold_result_after", result, res_fill(32'd24));

    // AW=16 instance: 4*255*255 = 260100 does not fit in 16 bits.
    @(negedge clock);
    h_mat = mat_fill(8'd255); h_in_valid = 1'b1;
    @(posedge clock); #1;
    h_in_valid = 1'b0;
    cyc = 1;
    while (!h_out_valid && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("aw16_latency", 32'(cyc), 32'd17);
    chk("aw16_ovf", h_ovf, 1'b1);
`ifdef MMAC_SATURATE_EN
    chk("aw16_result", h_result, res16_fill(16'hFFFF));
`else
    chk("aw16_result", h_result, res16_fill(16'hF804));
`endif
    @(negedge clock);
    h_out_ready = 1'b1;
    @(posedge clock); #1;
    h_out_ready = 1'b0;
    chk("aw16_ready_after", h_in_ready, 1'b1);

    // Reset while element 5 is about to be written.
    @(negedge clock);
    mat_a = mat_fill(8'd1); mat_b = mat_fill(8'd1); acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) part[i*32 +: 32] = (i < 5) ? 32'd4 : 32'd24;
    chk("mid_partial", result, part);
    chk("mid_state", dbg_state, 2'(COMPUTE));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_result", result, '0);
    chk("mid_rst_ovf", ovf, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rel_in_ready", in_ready, 1'b1);
    run_op(mat_ident(), mat_seq(), 1'b0, cyc, rdy_low);
    chk("post_rst_latency", 32'(cyc), 32'd17);
    chk("post_rst_result", result, res_seq());
    handoff();
    chk("post_rst_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
